// File: rtl/ethmac_check_crc_rx.sv
// Receive-side CRC-32 checker for the 16-bit MAC RX word stream.
// Checks the 802.3 residue and frame length, and keeps good/bad frame counters.
module ethmac_check_crc_rx #(
    parameter int          MIN_LEN     = 64,
    parameter int          MAX_LEN     = 1518,
    parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic        i_eof,
    input  logic        i_odd,
    input  logic        i_clr_cnt,
    output logic        o_result_valid,
    output logic        o_crc_ok,
    output logic        o_len_err,
    output logic [15:0] o_frame_len,
    output logic        o_seq_err,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_bad_cnt,
    output logic [31:0] o_crc
);

    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    typedef enum logic {IDLE, RUN} state_t;

    // Bytes enter the register LSB first, so each byte is bit-reversed before the MSB-first shift.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic [7:0]  d;
        c = crc;
        for (int i = 0; i < 8; i++) d[i] = data[7-i];
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] crc, input logic [15:0] data);
        return crc_byte(crc_byte(crc, data[15:8]), data[7:0]);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_in, crc_upd;
    logic [15:0] cnt_q, cnt_d, cnt_base, cnt_sum;
    logic [16:0] cnt_wide;
    logic [1:0]  add_bytes;
    logic        odd_last, accept, verdict, seq_err_d;

    assign odd_last  = i_eof & i_odd;
    assign crc_in    = i_sof ? 32'hFFFFFFFF : crc_q;
    assign crc_upd   = odd_last ? crc_byte(crc_in, i_data[15:8]) : crc_word(crc_in, i_data);
    assign add_bytes = odd_last ? 2'd1 : 2'd2;
    assign cnt_base  = i_sof ? 16'd0 : cnt_q;
    assign cnt_wide  = {1'b0, cnt_base} + {15'd0, add_bytes};
    assign cnt_sum   = cnt_wide[16] ? 16'hFFFF : cnt_wide[15:0];

    // A sof always (re)starts a frame; plain words only count while a frame is open.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        verdict   = 1'b0;
        seq_err_d = 1'b0;
        accept    = i_valid & (i_sof | (state_q == RUN));
        case (state_q)
            IDLE:    seq_err_d = i_valid & i_eof & ~i_sof;
            RUN:     seq_err_d = i_valid & i_sof;
            default: seq_err_d = 1'b0;
        endcase
        if (accept) begin
            crc_d   = crc_upd;
            cnt_d   = cnt_sum;
            state_d = i_eof ? IDLE : RUN;
            verdict = i_eof;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            crc_q          <= 32'hFFFFFFFF;
            cnt_q          <= 16'd0;
            o_result_valid <= 1'b0;
            o_crc_ok       <= 1'b0;
            o_len_err      <= 1'b0;
            o_frame_len    <= 16'd0;
            o_seq_err      <= 1'b0;
        end else begin
            state_q        <= state_d;
            crc_q          <= crc_d;
            cnt_q          <= cnt_d;
            o_result_valid <= verdict;
            o_seq_err      <= seq_err_d;
            if (verdict) begin
                o_crc_ok    <= (crc_d == CRC_RESIDUE);
                o_len_err   <= (cnt_d < MIN_L) || (cnt_d > MAX_L);
                o_frame_len <= cnt_d;
            end
        end
    end

    // Counters follow the registered verdict, so they settle one cycle after o_result_valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_good_cnt <= 16'd0;
            o_bad_cnt  <= 16'd0;
        end else if (i_clr_cnt) begin
            o_good_cnt <= 16'd0;
            o_bad_cnt  <= 16'd0;
        end else if (o_result_valid) begin
            if (o_crc_ok && !o_len_err) begin
                if (o_good_cnt != 16'hFFFF) o_good_cnt <= o_good_cnt + 16'd1;
            end else begin
                if (o_bad_cnt != 16'hFFFF) o_bad_cnt <= o_bad_cnt + 16'd1;
            end
        end
    end

    assign o_crc = crc_q;

endmodule

// File: tb/tb_ethmac_check_crc_rx.sv
// Scoreboard bench for ethmac_check_crc_rx: the driver queues expected verdicts,
// negedge monitors pop and compare whenever the DUT pulses a verdict or a sequence error.
module tb_ethmac_check_crc_rx;

    // Non-reflected register value after a single 0x00 byte from the seed, via the reflected algorithm.
    function automatic logic [31:0] zeroByteResidue();
        logic [31:0] r;
        logic [31:0] m;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        for (int i = 0; i < 32; i++) m[i] = r[31-i];
        return m;
    endfunction

    localparam logic [31:0] SAT_RES = zeroByteResidue();

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_data = 16'd0;
    logic        i_valid = 1'b0, i_sof = 1'b0, i_eof = 1'b0, i_odd = 1'b0, i_clr_cnt = 1'b0;
    logic        o_result_valid, o_crc_ok, o_len_err, o_seq_err;
    logic [15:0] o_frame_len, o_good_cnt, o_bad_cnt;
    logic [31:0] o_crc;

    logic [15:0] s_data = 16'd0;
    logic        s_valid = 1'b0, s_sof = 1'b0, s_eof = 1'b0, s_odd = 1'b0;
    logic        s_result_valid, s_crc_ok, s_len_err, s_seq_err;
    logic [15:0] s_frame_len, s_good_cnt, s_bad_cnt;
    logic [31:0] s_crc;

    ethmac_check_crc_rx dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
        .i_sof(i_sof), .i_eof(i_eof), .i_odd(i_odd), .i_clr_cnt(i_clr_cnt),
        .o_result_valid(o_result_valid), .o_crc_ok(o_crc_ok), .o_len_err(o_len_err),
        .o_frame_len(o_frame_len), .o_seq_err(o_seq_err), .o_good_cnt(o_good_cnt),
        .o_bad_cnt(o_bad_cnt), .o_crc(o_crc)
    );

    // One-byte frames with a matching residue make saturation reachable at one verdict per cycle.
    ethmac_check_crc_rx #(.MIN_LEN(1), .MAX_LEN(1518), .CRC_RESIDUE(SAT_RES)) dut_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(s_data), .i_valid(s_valid),
        .i_sof(s_sof), .i_eof(s_eof), .i_odd(s_odd), .i_clr_cnt(1'b0),
        .o_result_valid(s_result_valid), .o_crc_ok(s_crc_ok), .o_len_err(s_len_err),
        .o_frame_len(s_frame_len), .o_seq_err(s_seq_err), .o_good_cnt(s_good_cnt),
        .o_bad_cnt(s_bad_cnt), .o_crc(s_crc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          due;
        bit          crc_ok;
        bit          len_err;
        logic [15:0] len;
    } exp_t;

    exp_t        exp_q[$];
    int          seq_q[$];
    logic [7:0]  fb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          exp_good = 0;
    int          exp_bad = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge i_clk) begin : verdict_monitor
        exp_t e;
        if (i_rst_n && o_result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_verdict: got verdict at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("verdict_cycle", cyc, e.due);
                checkOutput("crc_ok", {31'd0, o_crc_ok}, {31'd0, e.crc_ok});
                checkOutput("len_err", {31'd0, o_len_err}, {31'd0, e.len_err});
                checkOutput("frame_len", {16'd0, o_frame_len}, {16'd0, e.len});
                if (e.crc_ok) checkOutput("final_crc", o_crc, 32'hC704DD7B);
            end
        end
    end

    always @(negedge i_clk) begin : seq_monitor
        if (i_rst_n && o_seq_err) begin
            if (seq_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_seq_err: got pulse at cycle %0d, expected none", cyc);
            end else begin
                checkOutput("seq_err_cycle", cyc, seq_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] refFcs();
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (fb[k]) begin
            r = r ^ {24'd0, fb[k]};
            for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return ~r;
    endfunction

    task automatic appendFcs();
        logic [31:0] f;
        f = refFcs();
        fb.push_back(f[7:0]);
        fb.push_back(f[15:8]);
        fb.push_back(f[23:16]);
        fb.push_back(f[31:24]);
    endtask

    task automatic driveWord(input logic [15:0] d, input bit sof, input bit eof, input bit odd);
        @(negedge i_clk);
        i_data = d; i_valid = 1'b1; i_sof = sof; i_eof = eof; i_odd = odd; i_clr_cnt = 1'b0;
    endtask

    task automatic idleCycle(input bit clr);
        @(negedge i_clk);
        i_data = 16'($urandom); i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0; i_odd = 1'b0;
        i_clr_cnt = clr;
    endtask

    task automatic pushVerdict(input int n, input bit ok);
        exp_t e;
        e.due = cyc + 1;
        e.crc_ok = ok;
        e.len_err = (n < 64) || (n > 1518);
        e.len = 16'(n);
        exp_q.push_back(e);
        if (ok && !e.len_err) begin
            if (exp_good < 65535) exp_good++;
        end else begin
            if (exp_bad < 65535) exp_bad++;
        end
    endtask

    task automatic applyStimulus(input bit gaps, input bit exp_ok, input bit exp_seq, input bit clr_after);
        int          n;
        int          nw;
        bit          last;
        logic [15:0] d;
        n = fb.size();
        nw = (n + 1) / 2;
        for (int w = 0; w < nw; w++) begin
            if (gaps && w > 0 && $urandom_range(0, 2) == 0) idleCycle(1'b0);
            last = (w == nw - 1);
            d[15:8] = fb[2*w];
            d[7:0] = (2*w + 1 < n) ? fb[2*w+1] : 8'h5A;
            driveWord(d, w == 0, last, last ? (n % 2 == 1) : 1'($urandom_range(0, 1)));
            if (w == 0 && exp_seq) seq_q.push_back(cyc + 1);
            if (last) pushVerdict(n, exp_ok);
        end
        idleCycle(clr_after);
        if (clr_after) begin
            exp_good = 0;
            exp_bad = 0;
        end
        idleCycle(1'b0);
        idleCycle(1'b0);
    endtask

    task automatic applyPartial(input int nwords);
        for (int w = 0; w < nwords; w++) driveWord({fb[2*w], fb[2*w+1]}, w == 0, 1'b0, 1'b0);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_good_cnt"}, {16'd0, o_good_cnt}, 32'(exp_good));
        checkOutput({tag, "_bad_cnt"}, {16'd0, o_bad_cnt}, 32'(exp_bad));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_crc"}, o_crc, 32'hFFFFFFFF);
        checkOutput({tag, "_result_valid"}, {31'd0, o_result_valid}, 32'd0);
        checkOutput({tag, "_crc_ok"}, {31'd0, o_crc_ok}, 32'd0);
        checkOutput({tag, "_len_err"}, {31'd0, o_len_err}, 32'd0);
        checkOutput({tag, "_frame_len"}, {16'd0, o_frame_len}, 32'd0);
        checkOutput({tag, "_seq_err"}, {31'd0, o_seq_err}, 32'd0);
        checkOutput({tag, "_good_cnt"}, {16'd0, o_good_cnt}, 32'd0);
        checkOutput({tag, "_bad_cnt"}, {16'd0, o_bad_cnt}, 32'd0);
    endtask

    task automatic buildFrame(input int ndata, input int mult);
        fb.delete();
        for (int i = 0; i < ndata; i++) fb.push_back(8'(i * mult));
        appendFcs();
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        checkResetState("reset");
        i_rst_n = 1'b1;
        idleCycle(1'b0);

        $display("[TB] check string with hand FCS, 13 bytes");
        fb = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkCounters("short");

        $display("[TB] 64-byte zero frame with gaps");
        buildFrame(60, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkCounters("zero64");

        $display("[TB] 64-byte zero frame, word 10 bit 0 flipped");
        fb[21] = fb[21] ^ 8'h01;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCounters("corrupt");

        $display("[TB] sof inside open frame, then good frame");
        buildFrame(60, 3);
        applyPartial(5);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkCounters("restart");

        $display("[TB] stray eof, then 1520-byte frame");
        driveWord(16'h1234, 1'b0, 1'b1, 1'b0);
        seq_q.push_back(cyc + 1);
        idleCycle(1'b0);
        buildFrame(1516, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkCounters("long");
        checkOutput("crc_hold", o_crc, 32'hC704DD7B);

        $display("[TB] counter clear alongside a verdict");
        buildFrame(60, 7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkCounters("clear");

        $display("[TB] reset in the middle of a frame");
        buildFrame(60, 5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyPartial(10);
        idleCycle(1'b0);
        #2 i_rst_n = 1'b0;
        #1 checkResetState("midreset");
        exp_good = 0;
        exp_bad = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) idleCycle(1'b0);
        checkCounters("after_reset");
        checkOutput("after_reset_crc", o_crc, 32'hFFFFFFFF);

        $display("[TB] saturating good counter");
        for (int k = 0; k < 65540; k++) begin
            @(negedge i_clk);
            s_data = 16'h00A5; s_valid = 1'b1; s_sof = 1'b1; s_eof = 1'b1; s_odd = 1'b1;
        end
        @(negedge i_clk);
        s_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("sat_good_cnt", {16'd0, s_good_cnt}, 32'h0000FFFF);
        checkOutput("sat_bad_cnt", {16'd0, s_bad_cnt}, 32'd0);
        checkOutput("sat_frame_len", {16'd0, s_frame_len}, 32'd1);
        checkOutput("sat_crc_ok", {31'd0, s_crc_ok}, 32'd1);

        checkOutput("pending_verdicts", 32'(exp_q.size()), 32'd0);
        checkOutput("pending_seq_errs", 32'(seq_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ethmac_check_crc_rx.md
Name: ethmac_check_crc_rx

Overview:
- Receive-side counterpart of the transmit CRC-32 append block. Sits in the MAC RX path on the same 16-bit word stream.
- Each 16-bit word carries two bytes; i_data[15:8] is the earlier byte on the wire.
- Runs the IEEE 802.3 CRC-32 over the whole frame, including the 4 FCS bytes, then checks the residue.
- Also checks frame length and keeps good/bad frame counters for the DHCP/EPA stack above.

Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1518: maximum legal frame length in bytes, FCS included.
- CRC_RESIDUE, 32'hC704DD7B: required register value after the last FCS byte (register not inverted).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_data  in  16  frame word; [15:8] is the first byte, [7:0] the second.
- i_valid  in  1  word qualifier; all other inputs are ignored when low.
- i_sof  in  1  with i_valid: first word of a frame.
- i_eof  in  1  with i_valid: last word of a frame.
- i_odd  in  1  with i_eof: only i_data[15:8] is valid in this word.
- i_clr_cnt  in  1  synchronous clear of both frame counters.
- o_result_valid  out  1  one-cycle pulse: frame verdict fields are valid.
- o_crc_ok  out  1  residue matched CRC_RESIDUE.
- o_len_err  out  1  length < MIN_LEN or > MAX_LEN.
- o_frame_len  out  16  byte count of the frame, FCS included.
- o_seq_err  out  1  one-cycle pulse on a framing protocol violation.
- o_good_cnt  out  16  saturating count of frames with crc_ok=1 and len_err=0.
- o_bad_cnt  out  16  saturating count of all other completed frames.
- o_crc  out  32  live CRC register, for debug.

Behaviour:
- Reset (asynchronous):
  - o_crc = 32'hFFFFFFFF; state = IDLE.
  - Every other output and the internal byte counter = 0.
- CRC update:
  - Each byte is bit-reversed before entering the register (802.3 LSB-first order), same mapping as the TX block.
  - 16-bit next-state function for full words; separate 8-bit next-state function for an odd last word.
  - No final inversion: the check compares the raw register against CRC_RESIDUE.
- State machine, IDLE / RUN:
  - IDLE + valid&sof: seed the register with FFFFFFFF, then update with the word; byte count = 2 (1 if eof&odd). Go to RUN unless eof is also set.
  - RUN + valid, no sof/eof: update; byte count += 2.
  - RUN + valid&eof: final update; byte count += 2, or += 1 if i_odd. Evaluate; go to IDLE.
  - sof&eof in the same word: a complete one-word frame; evaluated immediately.
  - valid low: hold everything. Gaps inside a frame are legal.
- Verdict timing and fields:
  - o_result_valid pulses exactly 1 cycle after the clock edge that accepted the eof word.
  - o_crc_ok, o_len_err and o_frame_len are registered at that same edge and held until the next verdict.
- Length arithmetic:
  - The byte counter is 16 bits and saturates at FFFF; it must not wrap.
  - o_len_err is computed on the final count.
- Counters:
  - Each is incremented by 1 on the o_result_valid cycle and saturates at FFFF.
  - i_clr_cnt zeroes both counters and has priority over an increment in the same cycle.
- Sequence errors (each gives an o_seq_err pulse 1 cycle later):
  - sof while in RUN: the open frame is dropped with no verdict and no counter change; the new frame starts with this word.
  - eof without sof while in IDLE: the word is ignored and the state stays IDLE.
- i_odd is ignored unless i_eof is set.
- o_crc after a verdict holds the final register; it is reseeded only on the next sof.
- Mid-frame reset: everything returns to the reset state; the partial frame produces no verdict.

Test Plan:
- ASCII frame "123456789" followed by FCS bytes 26 39 F4 CB (13 bytes, 7 words, last word odd):
  - o_result_valid 1 cycle after eof.
  - o_crc_ok=1, o_frame_len=13, o_len_err=1, o_bad_cnt=1.
- 60 zero bytes followed by their correct FCS (64 bytes, 32 words), with random i_valid gaps:
  - o_crc_ok=1, o_len_err=0, o_frame_len=64, o_good_cnt=1.
- Same 64-byte frame with bit 0 of word 10 flipped:
  - o_crc_ok=0, o_bad_cnt increments, o_good_cnt unchanged.
- Second sof at word 5 of an open frame, then a valid 64-byte frame:
  - o_seq_err pulse; exactly one verdict (ok); o_good_cnt +1 only.
- eof in IDLE, then a 1520-byte frame with correct FCS:
  - o_seq_err pulse, no verdict for the stray eof.
  - Frame verdict: o_crc_ok=1, o_len_err=1, o_frame_len=1520.
- Counter edge cases:
  - Drive 65540 good frames: o_good_cnt stays at FFFF.
  - i_clr_cnt in the same cycle as a verdict: both counters read 0 afterwards.
  - Async reset mid-frame: all outputs return to reset values, no verdict.
